// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU definitions: operation codes and main-control ALUOp class encodings.
// Used by the ID/EX issue stage, the ALU and main control.
package id_ex_alu_issue_pkg;

    // 4-bit ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b0111;

    // Main-control ALUOp class encodings
    localparam logic [1:0] CLASS_LDST   = 2'b00;
    localparam logic [1:0] CLASS_BRANCH = 2'b01;
    localparam logic [1:0] CLASS_RTYPE  = 2'b10;
    localparam logic [1:0] CLASS_ITYPE  = 2'b11;

    // funct3 values that carry an ALU meaning
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/id_ex_alu_issue_alu_op_decode.sv
// Combinational ALU-control decode: ALUOp class plus funct fields to a 4-bit
// ALU operation code. Unmapped R/I-type encodings raise illegal and fall back
// to ADD so the ALU always sees a defined operation.
module alu_op_decode
    import id_ex_alu_issue_pkg::*;
(
    input  logic [1:0] aluop_class_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] aluop_o,
    output logic       illegal_o
);

    // Map class/funct to an ALU code, flagging encodings with no legal mapping
    always_comb begin
        aluop_o   = ALU_ADD;
        illegal_o = 1'b0;
        case (aluop_class_i)
            CLASS_LDST: begin
                aluop_o = ALU_ADD;
            end
            CLASS_BRANCH: begin
                aluop_o = ALU_SUB;
            end
            CLASS_RTYPE: begin
                case (funct3_i)
                    F3_ADDSUB: begin
                        if (funct7_5_i) begin
                            aluop_o = ALU_SUB;
                        end else begin
                            aluop_o = ALU_ADD;
                        end
                    end
                    F3_AND: aluop_o = ALU_AND;
                    F3_OR:  aluop_o = ALU_OR;
                    F3_SLL: begin
                        if (funct7_5_i) begin
                            illegal_o = 1'b1;
                        end else begin
                            aluop_o = ALU_SLL;
                        end
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            CLASS_ITYPE: begin
                case (funct3_i)
                    // Bit 30 is part of the immediate for ADDI, so it is ignored
                    F3_ADDSUB: aluop_o = ALU_ADD;
                    F3_AND:    aluop_o = ALU_AND;
                    F3_OR:     aluop_o = ALU_OR;
                    F3_SLL: begin
                        if (funct7_5_i) begin
                            illegal_o = 1'b1;
                        end else begin
                            aluop_o = ALU_SLL;
                        end
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU path: decodes the ALU operation, selects
// operands and registers everything for EX. Reset and flush insert a bubble,
// stall holds the slot; illegal or invalid instructions never write state.
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_aluop_class,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              id_alusrc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_memtoreg,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [3:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_memtoreg,
    output logic              ex_illegal
);

    logic [3:0]        dec_aluop_s;
    logic              dec_illegal_s;
    logic              ctrl_ok_s;

    logic              valid_d,    valid_q;
    logic [DATA_W-1:0] a_d,        a_q;
    logic [DATA_W-1:0] b_d,        b_q;
    logic [DATA_W-1:0] store_d,    store_q;
    logic [3:0]        aluop_d,    aluop_q;
    logic [REG_AW-1:0] rd_d,       rd_q;
    logic              regwrite_d, regwrite_q;
    logic              memread_d,  memread_q;
    logic              memwrite_d, memwrite_q;
    logic              branch_d,   branch_q;
    logic              memtoreg_d, memtoreg_q;
    logic              illegal_d,  illegal_q;

    alu_op_decode u_alu_op_decode (
        .aluop_class_i (id_aluop_class),
        .funct3_i      (id_funct3),
        .funct7_5_i    (id_funct7_5),
        .aluop_o       (dec_aluop_s),
        .illegal_o     (dec_illegal_s)
    );

    // Load values for the EX slot: operand mux plus control gating
    always_comb begin
        ctrl_ok_s  = id_valid & ~dec_illegal_s;
        valid_d    = id_valid;
        a_d        = id_rs1_data;
        store_d    = id_rs2_data;
        rd_d       = id_rd;
        if (id_alusrc) begin
            b_d = id_imm;
        end else begin
            b_d = id_rs2_data;
        end
        if (ctrl_ok_s) begin
            aluop_d = dec_aluop_s;
        end else begin
            aluop_d = ALU_ADD;
        end
        regwrite_d = id_regwrite & ctrl_ok_s;
        memread_d  = id_memread  & ctrl_ok_s;
        memwrite_d = id_memwrite & ctrl_ok_s;
        branch_d   = id_branch   & ctrl_ok_s;
        memtoreg_d = id_memtoreg & id_valid;
        illegal_d  = id_valid & dec_illegal_s;
    end

    // EX slot register: reset/flush bubble, then stall hold, then load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q    <= 1'b0;
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            store_q    <= {DATA_W{1'b0}};
            aluop_q    <= ALU_ADD;
            rd_q       <= {REG_AW{1'b0}};
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (stall) begin
            valid_q    <= valid_q;
            a_q        <= a_q;
            b_q        <= b_q;
            store_q    <= store_q;
            aluop_q    <= aluop_q;
            rd_q       <= rd_q;
            regwrite_q <= regwrite_q;
            memread_q  <= memread_q;
            memwrite_q <= memwrite_q;
            branch_q   <= branch_q;
            memtoreg_q <= memtoreg_q;
            illegal_q  <= illegal_q;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            store_q    <= store_d;
            aluop_q    <= aluop_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            memtoreg_q <= memtoreg_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_a          = a_q;
    assign ex_b          = b_q;
    assign ex_store_data = store_q;
    assign ex_aluop      = aluop_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_branch     = branch_q;
    assign ex_memtoreg   = memtoreg_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: expected EX contents are pushed to a
// scoreboard when ID stimulus is driven and popped after the capturing edge.
module tb_id_ex_alu_issue;

    typedef struct packed {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] st;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        m2r;
        logic        ill;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [1:0]  id_aluop_class;
    logic [2:0]  id_funct3;
    logic        id_funct7_5, id_alusrc;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd;
    logic        id_regwrite, id_memread, id_memwrite, id_branch, id_memtoreg;
    logic        ex_valid;
    logic [63:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg, ex_illegal;

    int   checks   = 0;
    int   failures = 0;
    ex_t  sb[$];
    ex_t  last_exp;
    ex_t  exp_v, obs_v;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.DATA_W(64), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_aluop_class(id_aluop_class), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_alusrc(id_alusrc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_branch(id_branch), .id_memtoreg(id_memtoreg),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_memtoreg(ex_memtoreg),
        .ex_illegal(ex_illegal)
    );

    function automatic ex_t bubble();
        ex_t e;
        e    = '0;
        e.op = 4'b0010;
        return e;
    endfunction

    // Reference: returns {illegal, code} from the ALU-control truth table
    function automatic logic [4:0] ref_decode(input logic [1:0] cls, input logic [2:0] f3, input logic f7);
        logic [3:0] key;
        key = {f3, f7};
        if (cls == 2'b00) return {1'b0, 4'b0010};
        if (cls == 2'b01) return {1'b0, 4'b0110};
        if (key == 4'b0010) return {1'b0, 4'b0111};
        if (key == 4'b1110 || key == 4'b1111) return {1'b0, 4'b0000};
        if (key == 4'b1100 || key == 4'b1101) return {1'b0, 4'b0001};
        if (key == 4'b0000) return {1'b0, 4'b0010};
        if (key == 4'b0001 && cls == 2'b10) return {1'b0, 4'b0110};
        if (key == 4'b0001 && cls == 2'b11) return {1'b0, 4'b0010};
        return {1'b1, 4'b0010};
    endfunction

    function automatic ex_t model();
        ex_t        e;
        logic [4:0] d;
        logic       ok;
        if (reset || flush) return bubble();
        if (stall) return last_exp;
        d       = ref_decode(id_aluop_class, id_funct3, id_funct7_5);
        ok      = id_valid && !d[4];
        e.valid = id_valid;
        e.a     = id_rs1_data;
        e.b     = id_alusrc ? id_imm : id_rs2_data;
        e.st    = id_rs2_data;
        e.op    = ok ? d[3:0] : 4'b0010;
        e.rd    = id_rd;
        e.rw    = ok && id_regwrite;
        e.mr    = ok && id_memread;
        e.mw    = ok && id_memwrite;
        e.br    = ok && id_branch;
        e.m2r   = id_valid && id_memtoreg;
        e.ill   = id_valid && d[4];
        return e;
    endfunction

    function automatic ex_t observe();
        ex_t o;
        o.valid = ex_valid;  o.a  = ex_a;        o.b  = ex_b;        o.st  = ex_store_data;
        o.op    = ex_aluop;  o.rd = ex_rd;       o.rw = ex_regwrite; o.mr  = ex_memread;
        o.mw    = ex_memwrite; o.br = ex_branch; o.m2r = ex_memtoreg; o.ill = ex_illegal;
        return o;
    endfunction

    task automatic set_instr(input logic v, input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                             input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic [63:0] imm, input logic [4:0] rd, input logic [4:0] ctl);
        id_valid = v; id_aluop_class = cls; id_funct3 = f3; id_funct7_5 = f7; id_alusrc = src;
        id_rs1_data = rs1; id_rs2_data = rs2; id_imm = imm; id_rd = rd;
        {id_regwrite, id_memread, id_memwrite, id_branch, id_memtoreg} = ctl;
    endtask

    // Push the expected EX contents for the current ID inputs, then clock them in
    task automatic cycle_push();
        ex_t e;
        e = model();
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'h11, 64'h22, 64'h33, 5'd7, 5'b10000);
        for (int i = 0; i < 2; i++) begin
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL reset[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype_sub();
        set_instr(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 64'h10, 64'h3, 64'hABC, 5'd4, 5'b10000);
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v || ex_aluop !== 4'b0110) begin
            failures++; $display("FAIL rtype_sub got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_itype_ori();
        set_instr(1'b1, 2'b11, 3'b110, 1'b1, 1'b1, 64'h1234, 64'h55, 64'hFF, 5'd9, 5'b10000);
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v || ex_b !== 64'hFF || ex_store_data !== 64'h55) begin
            failures++; $display("FAIL itype_ori got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] f3f7 [4];
        f3f7 = '{4'b0100, 4'b0011, 4'b1010, 4'b0101};
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, (i % 2 == 0) ? 2'b10 : 2'b11, f3f7[i][3:1], f3f7[i][0], 1'b0,
                      64'h7, 64'h8, 64'h9, 5'd3, 5'b11110);
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v || ex_illegal !== 1'b1) begin
                failures++; $display("FAIL illegal[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_classes();
        logic [3:0] codes [6];
        for (int i = 0; i < 6; i++) begin
            set_instr(1'b1, (i < 3) ? 2'b00 : 2'b01, 3'(i * 3 + 2), 1'(i), 1'(i < 3),
                      64'(i) * 64'h1111, 64'hF0F0, 64'h40 + 64'(i), 5'(i + 20),
                      (i < 3) ? 5'b11001 : 5'b00010);
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL class[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
        // R-type and I-type legal mappings, incl. SLL and AND with bit 30 set
        codes = '{4'b1110, 4'b1101, 4'b0010, 4'b0000, 4'b0001, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            set_instr(1'b1, (i < 3) ? 2'b10 : 2'b11, codes[i][3:1], codes[i][0], 1'(i % 2),
                      64'hDEAD0000 + 64'(i), 64'hBEEF, 64'h5A + 64'(i), 5'(i + 1), 5'b10000);
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL legal[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_invalid();
        set_instr(1'b0, 2'b10, 3'b010, 1'b0, 1'b0, 64'h1, 64'h2, 64'h3, 5'd5, 5'b11111);
        cycle_push();
        exp_v = sb.pop_front(); checks++;
        if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg, ex_illegal}
            !== {exp_v.valid, exp_v.rw, exp_v.mr, exp_v.mw, exp_v.br, exp_v.m2r, exp_v.ill}) begin
            failures++; $display("FAIL invalid_bubble got=%b%b%b%b%b%b%b want=0000000", ex_valid,
                                 ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg, ex_illegal);
        end
    endtask

    task automatic test_stall();
        set_instr(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'hA, 64'hB, 64'hC, 5'd6, 5'b10000);
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL stall_load got=%h want=%h", obs_v, exp_v);
        end
        stall = 1'b1;
        set_instr(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 64'h77, 64'h3, 64'h0, 5'd8, 5'b10000);
        for (int i = 0; i < 3; i++) begin
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v || ex_aluop !== 4'b0010) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
        stall = 1'b0;
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v || ex_aluop !== 4'b0111) begin
            failures++; $display("FAIL stall_release got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush = 1'b1;
        set_instr(1'b1, 2'b10, 3'b111, 1'b0, 1'b1, 64'h99, 64'h98, 64'h97, 5'd2, 5'b11111);
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL stall_flush got=%h want=%h", obs_v, exp_v);
        end
        flush = 1'b0;
        // Reset while stalled also yields a bubble
        set_instr(1'b1, 2'b11, 3'b111, 1'b0, 1'b1, 64'h5, 64'h6, 64'h7, 5'd1, 5'b10000);
        stall = 1'b0;
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL pre_reset_load got=%h want=%h", obs_v, exp_v);
        end
        stall = 1'b1; reset = 1'b1;
        cycle_push();
        exp_v = sb.pop_front(); obs_v = observe(); checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL reset_mid_stall got=%h want=%h", obs_v, exp_v);
        end
        stall = 1'b0; reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            stall = (i > 0) && ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            set_instr(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cycle_push();
            exp_v = sb.pop_front(); obs_v = observe(); checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL b2b[%0d] got=%h want=%h", i, obs_v, exp_v);
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        last_exp = bubble();
        test_reset();
        test_rtype_sub();
        test_itype_ori();
        test_illegal();
        test_classes();
        test_invalid();
        test_stall();
        test_stall_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
